// File: rtl/distortion_pkg.sv
`default_nettype none
// ============================================================================
// Module      : distortion_pkg
// Description : Shared types and constants for the stereo distortion
//               controller: FSM state encoding, unity gain and the default
//               clip threshold (0.75 of full scale).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package distortion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROC_L = 2'd1,
        PROC_R = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Gain is Q3.5, so 32 is a gain of exactly 1.0.
    localparam int c_unity_gain        = 32;
    localparam int c_default_threshold = 24576;

endpackage : distortion_pkg
`default_nettype wire

// File: rtl/distortion_if.sv
`default_nettype none
// ============================================================================
// Module      : distortion_if
// Description : Stereo sample stream interface. It carries one input frame
//               per valid/ready handshake and one output frame back.
// Ports       : left_in/right_in/in_valid/in_ready   - input frame channel
//               left_out/right_out/out_valid/out_ready - output frame channel
//               master : the side that supplies frames and takes results
//               slave  : the processing side (distortion_ctrl)
// Revision    : 1.0 - initial release
// ============================================================================
interface distortion_if #(
    parameter int W = 16
) ();
    logic [W-1:0] left_in;
    logic [W-1:0] right_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] left_out;
    logic [W-1:0] right_out;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output left_in, right_in, in_valid, out_ready,
        input  in_ready, left_out, right_out, out_valid
    );

    modport slave (
        input  left_in, right_in, in_valid, out_ready,
        output in_ready, left_out, right_out, out_valid
    );
endinterface : distortion_if
`default_nettype wire

// File: rtl/distortion_core.sv
`default_nettype none
// ============================================================================
// Module      : distortion_core
// Description : Combinational gain + hard-clip unit, shared by both channels.
//               result = clamp((sample * gain) >>> GAIN_FRAC,
//                              -threshold, +threshold)
// Ports       : i_sample    - signed input sample
//               i_gain      - unsigned gain, GAIN_FRAC fractional bits
//               i_threshold - positive clip level
//               o_result    - scaled and clamped sample
//               o_clip      - high when the result was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module distortion_core #(
    parameter int W         = 16,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 5
) (
    input  logic [W-1:0]      i_sample,
    input  logic [GAIN_W-1:0] i_gain,
    input  logic [W-2:0]      i_threshold,
    output logic [W-1:0]      o_result,
    output logic              o_clip
);
    localparam int c_pw = W + GAIN_W + 1;

    logic signed [c_pw-1:0] w_sample_x;
    logic signed [c_pw-1:0] w_gain_x;
    logic signed [c_pw-1:0] w_prod;
    logic signed [c_pw-1:0] w_scaled;
    logic signed [c_pw-1:0] w_pos_lim;
    logic signed [c_pw-1:0] w_neg_lim;

    // Both operands are brought to full product width first so the multiply
    // is exact; the gain is zero-extended so it is always treated as positive.
    assign w_sample_x = {{(GAIN_W+1){i_sample[W-1]}}, i_sample};
    assign w_gain_x   = {{W{1'b0}}, i_gain};
    assign w_prod     = w_sample_x * w_gain_x;
    // Arithmetic shift: rounds toward minus infinity for negative products.
    assign w_scaled   = w_prod >>> GAIN_FRAC;
    assign w_pos_lim  = {{(GAIN_W+2){1'b0}}, i_threshold};
    assign w_neg_lim  = -w_pos_lim;

    always_comb begin
        o_result = w_scaled[W-1:0];
        o_clip   = 1'b0;
        if (w_scaled > w_pos_lim) begin
            o_result = w_pos_lim[W-1:0];
            o_clip   = 1'b1;
        end else if (w_scaled < w_neg_lim) begin
            o_result = w_neg_lim[W-1:0];
            o_clip   = 1'b1;
        end
    end
endmodule : distortion_core
`default_nettype wire

// File: rtl/distortion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : distortion_ctrl
// Description : Sequencing controller for the stereo distortion datapath.
//               Accepts one frame, runs left then right through a single
//               gain/clip unit, holds the result until taken downstream.
//               The applied gain ramps toward gain_target by at most
//               RAMP_STEP per accepted frame; clamped samples are counted.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               bus (slave)         - stereo frame in/out handshake
//               gain_target         - requested gain (Q3.5)
//               threshold           - positive clip level
//               bypass              - pass samples through unmodified
//               clip_clear          - zero the clip counter
//               clip_count          - saturating count of clamped samples
//               cur_gain            - gain applied to the latest frame
// Revision    : 1.0 - initial release
// ============================================================================
module distortion_ctrl
    import distortion_pkg::*;
#(
    parameter int W          = 16,
    parameter int GAIN_W     = 8,
    parameter int GAIN_FRAC  = 5,
    parameter int GAIN_RESET = c_unity_gain,
    parameter int RAMP_STEP  = 1
) (
    input  logic              clk,
    input  logic              reset,
    distortion_if.slave       bus,
    input  logic [GAIN_W-1:0] gain_target,
    input  logic [W-2:0]      threshold,
    input  logic              bypass,
    input  logic              clip_clear,
    output logic [15:0]       clip_count,
    output logic [GAIN_W-1:0] cur_gain
);
    localparam logic [GAIN_W-1:0] c_step = GAIN_W'(RAMP_STEP);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [W-1:0]      r_left;
    logic [W-1:0]      r_right;
    logic [W-2:0]      r_thr;
    logic              r_bypass;
    logic [W-1:0]      r_left_out;
    logic [W-1:0]      r_right_out;
    logic [GAIN_W-1:0] r_gain;
    logic [15:0]       r_clip_count;

    logic [GAIN_W-1:0] w_diff;
    logic [GAIN_W-1:0] w_gain_next;
    logic [W-1:0]      w_core_sample;
    logic [W-1:0]      w_core_result;
    logic              w_core_clip;
    logic [W-1:0]      w_chan_out;
    logic              w_clip_event;

    // Gain ramp: move toward the target, never overshooting it.
    always_comb begin
        w_diff      = '0;
        w_gain_next = r_gain;
        if (gain_target > r_gain) begin
            w_diff      = gain_target - r_gain;
            w_gain_next = r_gain + ((w_diff < c_step) ? w_diff : c_step);
        end else if (gain_target < r_gain) begin
            w_diff      = r_gain - gain_target;
            w_gain_next = r_gain - ((w_diff < c_step) ? w_diff : c_step);
        end
    end

    assign w_core_sample = (r_state == PROC_L) ? r_left : r_right;

    distortion_core #(
        .W         (W),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_core (
        .i_sample    (w_core_sample),
        .i_gain      (r_gain),
        .i_threshold (r_thr),
        .o_result    (w_core_result),
        .o_clip      (w_core_clip)
    );

    // Bypass keeps the same pipeline timing, only the result source changes.
    assign w_chan_out   = r_bypass ? w_core_sample : w_core_result;
    assign w_clip_event = ((r_state == PROC_L) || (r_state == PROC_R)) &&
                          w_core_clip && !r_bypass;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_left       <= '0;
            r_right      <= '0;
            r_thr        <= '0;
            r_bypass     <= 1'b0;
            r_left_out   <= '0;
            r_right_out  <= '0;
            r_gain       <= GAIN_W'(GAIN_RESET);
            r_clip_count <= '0;
        end else begin
            // Clear wins over a simultaneous clip.
            if (clip_clear) begin
                r_clip_count <= '0;
            end else if (w_clip_event && (r_clip_count != 16'hFFFF)) begin
                r_clip_count <= r_clip_count + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_left     <= bus.left_in;
                        r_right    <= bus.right_in;
                        r_thr      <= threshold;
                        r_bypass   <= bypass;
                        r_gain     <= w_gain_next;
                        r_in_ready <= 1'b0;
                        r_state    <= PROC_L;
                    end
                end
                PROC_L: begin
                    r_left_out <= w_chan_out;
                    r_state    <= PROC_R;
                end
                PROC_R: begin
                    r_right_out <= w_chan_out;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.left_out  = r_left_out;
    assign bus.right_out = r_right_out;
    assign clip_count    = r_clip_count;
    assign cur_gain      = r_gain;
endmodule : distortion_ctrl
`default_nettype wire

// File: tb/tb_distortion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_distortion_ctrl
// Description : Directed self-checking bench for distortion_ctrl. Inputs are
//               driven just after the rising edge, outputs sampled on the
//               falling edge. Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distortion_ctrl;
    import distortion_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  gain_target;
    logic [14:0] threshold;
    logic        bypass;
    logic        clip_clear;
    logic [15:0] clip_count;
    logic [7:0]  cur_gain;

    int checks = 0;
    int errors = 0;

    logic [15:0] lo, ro;

    distortion_if #(.W(16)) bus ();

    distortion_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .gain_target (gain_target),
        .threshold   (threshold),
        .bypass      (bypass),
        .clip_clear  (clip_clear),
        .clip_count  (clip_count),
        .cur_gain    (cur_gain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Runs one frame from IDLE (called on a falling edge). After acceptance
    // the live threshold/bypass/samples are scrambled to show the frame uses
    // the values captured at acceptance. Returns on a falling edge in IDLE.
    task automatic run_frame(input logic [15:0] l, input logic [15:0] r,
                             input logic clr,
                             output logic [15:0] lout, output logic [15:0] rout);
        logic [14:0] thr_save;
        logic        byp_save;
        bus.left_in   = l;
        bus.right_in  = r;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        clip_clear    = clr;
        chk("frame_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        thr_save      = threshold;
        byp_save      = bypass;
        threshold     = 15'd1;
        bypass        = ~bypass;
        bus.left_in   = 16'h1234;
        bus.right_in  = 16'h4321;
        @(negedge clk);
        chk("lat_procl_valid", bus.out_valid, 1'b0);
        chk("procl_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        clip_clear = 1'b0;
        chk("lat_procr_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("lat_hold_valid", bus.out_valid, 1'b1);
        lout      = bus.left_out;
        rout      = bus.right_out;
        threshold = thr_save;
        bypass    = byp_save;
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        gain_target   = 8'd32;
        threshold     = 15'(c_default_threshold);
        bypass        = 1'b0;
        clip_clear    = 1'b0;
        bus.left_in   = '0;
        bus.right_in  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_left_out", bus.left_out, 16'd0);
        chk("rst_right_out", bus.right_out, 16'd0);
        chk("rst_clip_count", clip_count, 16'd0);
        chk("rst_cur_gain", {8'd0, cur_gain}, 16'd32);
        reset = 1'b0;

        // Unity gain pass-through.
        run_frame(16'd1000, 16'hF830, 1'b0, lo, ro);
        chk("unity_left", lo, 16'd1000);
        chk("unity_right", ro, 16'hF830);
        chk("unity_count", clip_count, 16'd0);
        chk("unity_gain", {8'd0, cur_gain}, 16'd32);

        // Ramp 32 -> 40 one step per frame; left = 3200 * g / 32 = 100 * g.
        gain_target = 8'd40;
        for (int k = 1; k <= 9; k++) begin
            int g;
            g = (32 + k > 40) ? 40 : 32 + k;
            run_frame(16'd3200, 16'd0, 1'b0, lo, ro);
            chk("ramp_left", lo, 16'(100 * g));
            chk("ramp_gain", {8'd0, cur_gain}, 16'(g));
        end

        // Ramp on to 64 (24 more frames).
        gain_target = 8'd64;
        for (int k = 0; k < 24; k++) run_frame(16'd0, 16'd0, 1'b0, lo, ro);
        chk("ramp64_gain", {8'd0, cur_gain}, 16'd64);

        // Clip both channels: 20000 * 2 = 40000 clamps to +/-24576.
        run_frame(16'd20000, 16'hB1E0, 1'b0, lo, ro);
        chk("clip_left", lo, 16'd24576);
        chk("clip_right", ro, 16'hA000);
        chk("clip_count2", clip_count, 16'd2);

        // Clear held across the cycle the left channel clips: clear wins.
        run_frame(16'd20000, 16'd0, 1'b1, lo, ro);
        chk("clr_left", lo, 16'd24576);
        chk("clr_count", clip_count, 16'd0);

        // Backpressure: HOLD for 5 cycles with a second frame waiting.
        bus.left_in   = 16'd100;
        bus.right_in  = 16'd100;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.left_in  = 16'd7;
        bus.right_in = 16'd7;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", bus.out_valid, 1'b1);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_left", bus.left_out, 16'd200);
            chk("bp_right", bus.right_out, 16'd200);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_in_ready", bus.in_ready, 1'b1);
        chk("bp_idle_out_valid", bus.out_valid, 1'b0);
        chk("bp_idle_left_stable", bus.left_out, 16'd200);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_accepted", bus.in_ready, 1'b0);
        repeat (2) @(negedge clk);
        chk("bp_next_valid", bus.out_valid, 1'b1);
        chk("bp_next_left", bus.left_out, 16'd14);
        @(negedge clk);

        // Bypass: samples pass unchanged, no counting, ramp still moves 64->63.
        gain_target = 8'd60;
        bypass      = 1'b1;
        run_frame(16'h8000, 16'h7FFF, 1'b0, lo, ro);
        chk("byp_left", lo, 16'h8000);
        chk("byp_right", ro, 16'h7FFF);
        chk("byp_count", clip_count, 16'd0);
        chk("byp_gain", {8'd0, cur_gain}, 16'd63);
        bypass      = 1'b0;
        gain_target = 8'd63;

        // Rounding toward minus infinity: -1*63>>>5 = -2, 1*63>>>5 = 1.
        run_frame(16'hFFFF, 16'd1, 1'b0, lo, ro);
        chk("round_left", lo, 16'hFFFE);
        chk("round_right", ro, 16'd1);

        // Zero threshold forces zero and counts both clamps.
        threshold = 15'd0;
        run_frame(16'd5, 16'hFFFB, 1'b0, lo, ro);
        chk("thr0_left", lo, 16'd0);
        chk("thr0_right", ro, 16'd0);
        chk("thr0_count", clip_count, 16'd2);
        threshold = 15'(c_default_threshold);

        // Saturation: preload near the top, two clips must stop at 65535.
        force dut.r_clip_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_clip_count;
        run_frame(16'd20000, 16'hB1E0, 1'b0, lo, ro);
        chk("sat_left", lo, 16'd24576);
        chk("sat_count", clip_count, 16'hFFFF);
        run_frame(16'd20000, 16'hB1E0, 1'b0, lo, ro);
        chk("sat_hold", clip_count, 16'hFFFF);

        // Reset while processing the right channel.
        bus.left_in  = 16'd1;
        bus.right_in = 16'd1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_gain", {8'd0, cur_gain}, 16'd32);
        chk("midrst_count", clip_count, 16'd0);
        repeat (2) @(negedge clk);
        chk("midrst_no_output", bus.out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_distortion_ctrl
`default_nettype wire
